// File: rtl/uart_pkg.sv
// Shared types and constants for the UART capture block: parity encodings,
// receiver FSM states and a counter-width helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  // Bits needed to hold values 0..n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word; accepts push and pop in the
// same cycle even when full. rdata holds its last value once empty.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_nxt;
  logic             do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_nxt  = rd_ptr + 1'b1;

  always_ff @(posedge HCLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rdata  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // Head register tracks the next oldest entry; a lone survivor being
      // popped hands over directly to the word being written.
      if (do_pop) begin
        if (level > (AW+1)'(1)) rdata <= mem[rd_nxt];
        else if (do_push)       rdata <= wdata;
      end else if (empty && do_push) begin
        rdata <= wdata;
      end
    end
  end

endmodule

// File: rtl/uart_rx_capture.sv
// UART receiver with configurable framing and oversampling; captured frames
// and their parity/framing status are queued in a FIFO for a host consumer.
module uart_rx_capture import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          rx,
  output logic [DATA_BITS+1:0]          rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic                          overrun,
  input  logic                          clr,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int BW = cnt_width(DATA_BITS);

  logic [1:0]           sync;
  logic                 rx_s;
  rx_state_e            state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bidx;
  logic                 sidx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err, frm_err, push_q;
  logic                 stop_bad, tick;
  logic                 fifo_full, fifo_empty, drop;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) sync <= 2'b11;
    else        sync <= {sync[0], rx};
  end
  assign rx_s = sync[1];

  assign tick     = (cnt == '0);
  assign stop_bad = frm_err | ~rx_s;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      bidx    <= '0;
      sidx    <= 1'b0;
      shreg   <= '0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
      push_q  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          cnt   <= CW'(CLKS_PER_BIT/2 - 1);
        end
        START: if (tick) begin
          if (rx_s) state <= IDLE;
          else begin
            state   <= DATA;
            cnt     <= CW'(CLKS_PER_BIT - 1);
            bidx    <= '0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
          end
        end else cnt <= cnt - 1'b1;
        DATA: if (tick) begin
          shreg <= {rx_s, shreg[DATA_BITS-1:1]};
          cnt   <= CW'(CLKS_PER_BIT - 1);
          if (bidx == BW'(DATA_BITS - 1)) begin
            state <= (PARITY != PAR_NONE) ? PAR : STOP;
            sidx  <= 1'b0;
          end else bidx <= bidx + 1'b1;
        end else cnt <= cnt - 1'b1;
        PAR: if (tick) begin
          // Odd parity wants an odd count of ones over data+parity bit.
          par_err <= (^{shreg, rx_s}) ^ (PARITY == PAR_ODD);
          state   <= STOP;
          cnt     <= CW'(CLKS_PER_BIT - 1);
        end else cnt <= cnt - 1'b1;
        STOP: if (tick) begin
          frm_err <= stop_bad;
          if (sidx == 1'(STOP_BITS - 1)) begin
            push_q <= 1'b1;
            state  <= stop_bad ? WAIT_IDLE : IDLE;
          end else begin
            sidx <= 1'b1;
            cnt  <= CW'(CLKS_PER_BIT - 1);
          end
        end else cnt <= cnt - 1'b1;
        WAIT_IDLE: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .push   (push_q),
    .pop    (rd_ready),
    .wdata  ({par_err, frm_err, shreg}),
    .rdata  (rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (level)
  );

  assign rd_valid = ~fifo_empty;
  assign drop     = push_q & fifo_full & ~(rd_ready & ~fifo_empty);

  // A new drop outranks a clear landing in the same cycle.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)   overrun <= 1'b0;
    else if (drop) overrun <= 1'b1;
    else if (clr)  overrun <= 1'b0;
  end

endmodule

// File: doc/uart_rx_capture.md
# uart_rx_capture

Parametrised, synthesizable UART receiver with a receive FIFO. It generalises the fixed 8N1 serial terminal monitor to configurable data width, parity, stop bits and oversampling. It adds error detection and buffered, handshaked read-out. It sits on the UART TX pin of an SoC under test, in bench or on FPGA, and feeds captured characters plus per-character status to a host-side consumer.

## Interface
- CLKS_PER_BIT, 16, HCLK cycles per UART bit; even, ≥4
- DATA_BITS, 8, data bits per frame, 5–9
- PARITY, 0, 0 none / 1 odd / 2 even
- STOP_BITS, 1, 1 or 2
- FIFO_DEPTH, 16, receive FIFO entries; power of two, ≥2
- HCLK  in  1  clock; single clock domain
- HRESET  in  1  asynchronous, active-high reset
- rx  in  1  serial line, asynchronous, idle high
- rd_data  out  DATA_BITS+2  {parity_err, frame_err, data}; data is LSB-first assembled
- rd_valid  out  1  FIFO non-empty
- rd_ready  in  1  consumer pops the head when rd_valid & rd_ready
- overrun  out  1  sticky: a frame was dropped because the FIFO was full
- clr  in  1  synchronous clear of overrun
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- rx passes through a 2-flop synchroniser reset to 1; the FSM sees only rx_s.
- FSM states: IDLE, START, DATA, PAR, STOP, WAIT_IDLE.
- IDLE: rx_s==0 → START and load bit counter with CLKS_PER_BIT/2-1.
- START: at counter 0, sample rx_s. If 1, it is a false start → IDLE. If 0 → DATA and reload counter with CLKS_PER_BIT-1.
- DATA: sample at each counter 0 and shift into bit DATA_BITS-1, right-shifting, for LSB-first. After DATA_BITS samples → PAR if PARITY≠0, else STOP.
- PAR: sample. parity_err = computed parity mismatch: odd requires XOR(data,p)=1, even requires 0. Always 0 when PARITY=0.
- STOP: sample STOP_BITS bits. frame_err = any stop sample ==0.
- The frame is pushed on the cycle the last stop bit is sampled.
- After push: frame_err=0 → IDLE; frame_err=1 → WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1 (break/line-low tolerance), then → IDLE.
- Frames with errors are still pushed; status travels in rd_data.
- FIFO full at push with no simultaneous pop: frame is dropped, overrun←1, FIFO unchanged.
- Full with rd_valid&rd_ready in the same cycle: pop and push both occur, no overrun, level unchanged.
- Empty: rd_ready ignored; rd_data holds the last value.
- clr in the same cycle as a new overrun event: overrun stays 1, because set wins.

## Timing
- Reset values: rd_valid=0, rd_data=0, overrun=0, level=0, FSM=IDLE, synchroniser=1'b1.
- Async assertion of HRESET mid-frame aborts immediately. After release, the block waits in IDLE for the next falling edge. A frame already in progress is not resynchronised beyond that rule.
- Latency: pin falling edge at cycle 0 → push at cycle 2 + CLKS_PER_BIT/2 + (DATA_BITS + (PARITY≠0) + STOP_BITS-1)·CLKS_PER_BIT + CLKS_PER_BIT.
- rd_valid rises one cycle after the push, and the new entry is visible on rd_data then.
- 8N1 at CLKS_PER_BIT=16: rd_valid rises at cycle 155.
- Pop: rd_data/rd_valid/level update the cycle after the rd_valid&rd_ready edge. First-word data is registered FIFO output, not fall-through.
- Back-to-back frames: a falling edge seen in IDLE the cycle after the push is accepted with no gap required.

## Structure
- Package uart_pkg: parity encoding constants (PAR_NONE/ODD/EVEN), FSM state enum, helper function for bit-counter width.
- One sub-module, sync_fifo (WIDTH, DEPTH), providing push/pop/full/empty/level and simultaneous push-pop when full. The top holds the synchroniser, FSM, shift register and counters.

## Test plan
- 8N1, CLKS_PER_BIT=16, send 0x55 → rd_valid at cycle 155, rd_data=10'h055; pop clears rd_valid next cycle.
- 8E1, send 0xA3 with parity bit forced wrong → rd_data=10'h2A3 (parity_err=1). 7O2 with 0x41 and correct parity → 9'h041.
- 8N1, stop bit held 0 for 3 bit times, then idle → rd_data frame_err=1, no spurious second frame before rx returns high.
- 200-cycle-wide... 4-cycle low glitch on idle rx → no push, FSM back in IDLE.
- FIFO_DEPTH=4, send 6 frames with rd_ready=0 → level=4, overrun=1, entries = first four bytes. clr → overrun=0. Pop while pushing when full → no overrun.
- HRESET pulsed mid-data-bit → all outputs at reset values. The next clean frame 0x3C is received correctly.
